// File: rtl/fir_pkg.sv
// Constants shared by the FIR filter and its downstream stages.
package fir_pkg;
  localparam int unsigned FIR_WIDTH = 16;
  localparam int unsigned FIR_TAPS  = 20;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head: a push into an empty FIFO is visible one edge later.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             empty, do_push, do_pop;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop_i & ~empty;
  // A pop frees the slot this cycle, so push is allowed even when full.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q + LW'(do_push) - LW'(do_pop);
    rd_d    = rd_q + AW'(do_pop);
    wr_d    = wr_q + AW'(do_push);
    valid_d = (count_d != '0);
    head_d  = head_q;
    // The incoming word becomes head only when nothing older remains after the pop.
    if (do_push && ((count_q - LW'(do_pop)) == '0))
      head_d = din_i;
    else if (count_d != '0)
      head_d = mem_q[rd_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign level_o = count_q;
endmodule

// File: rtl/fir_decim_buffer.sv
// Drops the FIR warm-up transient, decimates by DECIM and queues kept samples for a ready/valid sink.
module fir_decim_buffer
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH  = FIR_WIDTH,
  parameter int unsigned DECIM  = 2,
  parameter int unsigned WARMUP = FIR_TAPS,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_sample,
  input  logic                   in_en,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clear_ovf
);
  localparam int unsigned WW = $clog2(WARMUP + 1);
  localparam int unsigned PW = $clog2(DECIM + 1);

  logic [WW-1:0] warm_q, warm_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          ovf_q, ovf_d;
  logic          warm_done, kept, pop, full;

  assign warm_done = (warm_q == WW'(WARMUP));
  assign kept      = in_en & warm_done & (phase_q == '0);
  assign pop       = out_valid & out_ready;

  always_comb begin
    warm_d  = warm_q;
    phase_d = phase_q;
    ovf_d   = ovf_q;
    if (in_en && !warm_done)
      warm_d = warm_q + WW'(1);
    if (in_en && warm_done)
      phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
    // A drop in the same cycle overrides a clear request.
    if (kept && full && !pop)
      ovf_d = 1'b1;
    else if (clear_ovf)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_q  <= '0;
      phase_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      warm_q  <= warm_d;
      phase_q <= phase_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (kept),
    .pop_i   (pop),
    .din_i   (in_sample),
    .head_o  (out_data),
    .valid_o (out_valid),
    .full_o  (full),
    .level_o (level)
  );

  assign overflow = ovf_q;
endmodule

// File: tb/tb_fir_decim_buffer.sv
// Directed checks of warm-up, decimation, back-pressure, overflow and async reset.
module tb_fir_decim_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_sample;
  logic        in_en;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic        overflow;
  logic        clear_ovf;

  int vectors = 0;
  int errs    = 0;

  fir_decim_buffer #(.WIDTH(16), .DECIM(2), .WARMUP(20), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_sample (in_sample),
    .in_en     (in_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] v, input logic en);
    in_sample = v;
    in_en     = en;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_en = 1'b0; in_sample = '0; out_ready = 1'b0; clear_ovf = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Feeds ramp samples k = 0..last (post-reset cycle index) with in_en=1.
  task automatic ramp_to(input int last);
    for (int k = 0; k <= last; k++) feed(16'(k), 1'b1);
  endtask

  initial begin
    logic [15:0] exp_head;

    // Reset state
    do_reset();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", {16'b0, out_data}, 32'd0);
    chk("rst_level", {28'b0, level}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);

    // 1: ramp with ready high
    out_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      feed(16'(k), 1'b1);
      if (k < 20) begin
        chk("warm_valid", {31'b0, out_valid}, 32'd0);
      end else if (k % 2 == 0) begin
        chk("ramp_valid", {31'b0, out_valid}, 32'd1);
        chk("ramp_data", {16'b0, out_data}, 32'(k));
        chk("ramp_level", {28'b0, level}, 32'd1);
      end else begin
        chk("ramp_drain", {31'b0, out_valid}, 32'd0);
        chk("ramp_level0", {28'b0, level}, 32'd0);
      end
    end
    chk("ramp_ovf", {31'b0, overflow}, 32'd0);

    // 2: back-pressure, 36 dropped, drain in order then 38
    do_reset();
    ramp_to(34);
    chk("bp_level8", {28'b0, level}, 32'd8);
    chk("bp_head20", {16'b0, out_data}, 32'd20);
    chk("bp_ovf0", {31'b0, overflow}, 32'd0);
    feed(16'd35, 1'b1);
    feed(16'd36, 1'b1);
    chk("bp_ovf1", {31'b0, overflow}, 32'd1);
    chk("bp_level_keep", {28'b0, level}, 32'd8);
    chk("bp_head_keep", {16'b0, out_data}, 32'd20);
    out_ready = 1'b1;
    exp_head = 16'd20;
    for (int k = 37; k < 60; k++) begin
      if (out_valid) begin
        chk("bp_pop", {16'b0, out_data}, {16'b0, exp_head});
        exp_head = (exp_head == 16'd34) ? 16'd38 : exp_head + 16'd2;
      end
      feed(16'(k), 1'b1);
      if (k == 37) chk("bp_lvl37", {28'b0, level}, 32'd7);
      if (k == 40) chk("bp_lvl40", {28'b0, level}, 32'd6);
    end
    chk("bp_popped_past_36", {16'b0, exp_head}, 32'd60);
    chk("bp_ovf_sticky", {31'b0, overflow}, 32'd1);

    // 3: full + kept + pop in one cycle
    do_reset();
    ramp_to(35);
    chk("fkp_pre_level", {28'b0, level}, 32'd8);
    out_ready = 1'b1;
    feed(16'd36, 1'b1);
    out_ready = 1'b0;
    chk("fkp_level", {28'b0, level}, 32'd8);
    chk("fkp_head", {16'b0, out_data}, 32'd22);
    chk("fkp_ovf", {31'b0, overflow}, 32'd0);

    // 6: clear_ovf on non-drop clears; on drop cycle set wins
    feed(16'd37, 1'b1);
    feed(16'd38, 1'b1);
    chk("co_set", {31'b0, overflow}, 32'd1);
    clear_ovf = 1'b1;
    feed(16'd39, 1'b1);
    chk("co_clear", {31'b0, overflow}, 32'd0);
    feed(16'd40, 1'b1);
    chk("co_set_wins", {31'b0, overflow}, 32'd1);
    clear_ovf = 1'b0;
    feed(16'd41, 1'b1);
    chk("co_hold", {31'b0, overflow}, 32'd1);

    // 5: async reset between edges with level=5, overflow=1
    out_ready = 1'b1;
    feed(16'd0, 1'b0);
    feed(16'd0, 1'b0);
    feed(16'd0, 1'b0);
    out_ready = 1'b0;
    chk("ar_pre_level", {28'b0, level}, 32'd5);
    chk("ar_pre_ovf", {31'b0, overflow}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_level", {28'b0, level}, 32'd0);
    chk("ar_ovf", {31'b0, overflow}, 32'd0);
    chk("ar_data", {16'b0, out_data}, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    ramp_to(19);
    chk("ar_rewarm", {31'b0, out_valid}, 32'd0);
    feed(16'd20, 1'b1);
    chk("ar_first_valid", {31'b0, out_valid}, 32'd1);
    chk("ar_first_data", {16'b0, out_data}, 32'd20);

    // 4: in_en gating, negative sample passes bit-exact
    do_reset();
    out_ready = 1'b1;
    ramp_to(19);
    feed(16'hFFFB, 1'b1);
    chk("ge_kept", {16'b0, out_data}, 32'h0000FFFB);
    chk("ge_valid", {31'b0, out_valid}, 32'd1);
    feed(16'hFFFB, 1'b0);
    chk("ge_off_empty", {31'b0, out_valid}, 32'd0);
    feed(16'd7, 1'b1);
    chk("ge_phase1_skip", {31'b0, out_valid}, 32'd0);
    feed(16'd99, 1'b0);
    chk("ge_frozen_skip", {31'b0, out_valid}, 32'd0);
    feed(16'hFFFB, 1'b1);
    chk("ge_kept2_valid", {31'b0, out_valid}, 32'd1);
    chk("ge_kept2_data", {16'b0, out_data}, 32'h0000FFFB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
